// File: rtl/demux_pkg.sv
// Shared types and constants for the 8-way round-robin decoder-style arbiter.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DEAD  = 2'd2
  } state_e;

  localparam int NREQ = 8;
  localparam int IDXW = 3;
  localparam logic [NREQ-1:0] NONE_SEL = 8'hFF;

  // Active-low one-hot select, same shape as a 3-to-8 decoder output.
  function automatic logic [NREQ-1:0] sel_low(input logic [IDXW-1:0] idx);
    return ~(NREQ'(1) << idx);
  endfunction

endpackage

// File: rtl/demux_arbiter_rr_priority_8.sv
// Combinational rotating-priority picker: first set request scanning up from ptr, wrapping 7->0.
module rr_priority_8
  import demux_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [IDXW-1:0] o_idx,
  output logic            o_found
);

  logic [IDXW-1:0] w_pos;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = i_ptr + IDXW'(k);
      if (i_req[w_pos]) begin
        o_idx   = w_pos;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_arbiter.sv
// Round-robin arbiter driving an active-low one-hot select with a guaranteed idle gap
// between grants and a bounded hold time.
//   state | meaning
//   IDLE  | nobody selected; pick next requester from ptr when enabled
//   GRANT | one requester selected; timer counts hold cycles
//   DEAD  | forced all-high gap of DEAD_CYCLES cycles after a release
module demux_arbiter
  import demux_pkg::*;
#(
  parameter int DEAD_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [NREQ-1:0] nreq,
  input  logic            ng,
  output logic [NREQ-1:0] ngrant,
  output logic [IDXW-1:0] gidx,
  output logic            gvalid,
  output logic            ntimeout
);

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [3:0] DEAD_LOAD = (DEAD_CYCLES > 0) ? 4'(DEAD_CYCLES - 1) : 4'd0;

  state_e          r_state, w_state_nxt;
  logic [IDXW-1:0] r_ptr, w_ptr_nxt;
  logic [7:0]      r_timer, w_timer_nxt;
  logic [3:0]      r_dead, w_dead_nxt;
  logic [NREQ-1:0] r_ngrant, w_ngrant_nxt;
  logic [IDXW-1:0] r_gidx, w_gidx_nxt;
  logic            r_gvalid, w_gvalid_nxt;
  logic            r_ntimeout, w_ntimeout_nxt;

  logic [NREQ-1:0] w_req;
  logic            w_en;
  logic [IDXW-1:0] w_pick;
  logic            w_found;
  logic            w_timeout;

  // Only a clean 0 is a request; X/Z behaves like the decoder's all-high default.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_req[i] = (nreq[i] === 1'b0);
    end
  end

  assign w_en      = (ng === 1'b0);
  assign w_timeout = (HOLD_MAX != 8'd0) && (r_timer == HOLD_MAX);

  rr_priority_8 u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_timer    <= '0;
      r_dead     <= '0;
      r_ngrant   <= NONE_SEL;
      r_gidx     <= '0;
      r_gvalid   <= 1'b0;
      r_ntimeout <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_timer    <= w_timer_nxt;
      r_dead     <= w_dead_nxt;
      r_ngrant   <= w_ngrant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_gvalid   <= w_gvalid_nxt;
      r_ntimeout <= w_ntimeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_timer_nxt    = r_timer;
    w_dead_nxt     = r_dead;
    w_ngrant_nxt   = r_ngrant;
    w_gidx_nxt     = r_gidx;
    w_gvalid_nxt   = r_gvalid;
    w_ntimeout_nxt = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_en && w_found) begin
          w_ngrant_nxt = sel_low(w_pick);
          w_gidx_nxt   = w_pick;
          w_gvalid_nxt = 1'b1;
          w_timer_nxt  = 8'd1;
          w_state_nxt  = GRANT;
        end
      end
      GRANT: begin
        // Disable wins over timeout, so a gated release never pulses ntimeout.
        if (!w_en || w_timeout || !w_req[r_gidx]) begin
          w_ngrant_nxt   = NONE_SEL;
          w_gvalid_nxt   = 1'b0;
          w_ptr_nxt      = r_gidx + IDXW'(1);
          w_ntimeout_nxt = !(w_en && w_timeout);
          w_dead_nxt     = DEAD_LOAD;
          w_state_nxt    = (DEAD_CYCLES > 0) ? DEAD : IDLE;
        end else if (r_timer != 8'hFF) begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      DEAD: begin
        if (r_dead == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_dead_nxt = r_dead - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ngrant   = r_ngrant;
  assign gidx     = r_gidx;
  assign gvalid   = r_gvalid;
  assign ntimeout = r_ntimeout;

endmodule

// File: tb/tb_demux_arbiter.sv
// Directed bench for demux_arbiter with DEAD_CYCLES=1, MAX_HOLD=4.
module tb_demux_arbiter;
  import demux_pkg::*;

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] nreq;
  logic       ng;
  logic [7:0] ngrant;
  logic [2:0] gidx;
  logic       gvalid;
  logic       ntimeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux_arbiter #(.DEAD_CYCLES(1), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .nreq     (nreq),
    .ng       (ng),
    .ngrant   (ngrant),
    .gidx     (gidx),
    .gvalid   (gvalid),
    .ntimeout (ntimeout)
  );

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = gvalid;
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; nreq = 8'hFF; ng = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (ngrant !== 8'hFF) begin n_fail++; $display("FAIL reset_ngrant: got %h want ff", ngrant); end
    n_tests++; if (gidx !== 3'd0) begin n_fail++; $display("FAIL reset_gidx: got %0d want 0", gidx); end
    n_tests++; if (gvalid !== 1'b0) begin n_fail++; $display("FAIL reset_gvalid: got %b want 0", gvalid); end
    n_tests++; if (ntimeout !== 1'b1) begin n_fail++; $display("FAIL reset_ntimeout: got %b want 1", ntimeout); end
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    nreq = 8'hF7;
    #1;
    n_tests++; if (ngrant !== 8'hFF) begin n_fail++; $display("FAIL single_no_comb: got %h want ff", ngrant); end
    @(negedge clk);
    n_tests++; if (ngrant !== 8'hF7 || gidx !== 3'd3 || gvalid !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: got ngrant=%h gidx=%0d gvalid=%b want f7/3/1", ngrant, gidx, gvalid); end
    @(negedge clk);
    nreq = 8'hFF;
    @(negedge clk);
    n_tests++; if (ngrant !== 8'hFF || gvalid !== 1'b0 || gidx !== 3'd3) begin
      n_fail++; $display("FAIL single_release: got ngrant=%h gidx=%0d gvalid=%b want ff/3/0", ngrant, gidx, gvalid); end
    nreq = 8'hF7;
    @(negedge clk);
    n_tests++; if (ngrant !== 8'hFF) begin n_fail++; $display("FAIL single_gap: got %h want ff", ngrant); end
    @(negedge clk);
    n_tests++; if (ngrant !== 8'hF7) begin n_fail++; $display("FAIL single_regrant: got %h want f7", ngrant); end
    nreq = 8'hFF;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    bit ok;
    nreq = 8'hFB;
    wait_grant(6, ok);
    n_tests++; if (!ok || gidx !== 3'd2 || ngrant !== 8'hFB) begin
      n_fail++; $display("FAIL midrst_grant: got ok=%b gidx=%0d ngrant=%h want 1/2/fb", ok, gidx, ngrant); end
    #2 nreset = 1'b0;
    #1;
    n_tests++; if (ngrant !== 8'hFF || gvalid !== 1'b0 || gidx !== 3'd0 || ntimeout !== 1'b1) begin
      n_fail++; $display("FAIL midrst_async: got ngrant=%h gvalid=%b gidx=%0d ntimeout=%b want ff/0/0/1",
                         ngrant, gvalid, gidx, ntimeout); end
    nreq = 8'hFF;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] prev;
    logic [2:0] e_idx;
    int ngr, held;
    bit pv;
    prev = 8'hFF; ngr = 0; held = 0; pv = 1'b0;
    nreq = 8'h00;
    for (int c = 0; c < 80 && ngr < 9; c++) begin
      @(negedge clk);
      n_tests++; if ($countones(~ngrant) > 1 || (!gvalid && ngrant !== 8'hFF)) begin
        n_fail++; $display("FAIL rr_onehot: got ngrant=%h gvalid=%b want at most one low bit", ngrant, gvalid); end
      n_tests++; if (prev !== 8'hFF && ngrant !== 8'hFF && ngrant !== prev) begin
        n_fail++; $display("FAIL rr_gap: got %h after %h want ff between grants", ngrant, prev); end
      if (gvalid && !pv) begin
        e_idx = 3'(ngr);
        n_tests++; if (gidx !== e_idx || ngrant !== ~(8'h01 << e_idx)) begin
          n_fail++; $display("FAIL rr_order: got gidx=%0d ngrant=%h want %0d", gidx, ngrant, e_idx); end
        ngr++;
        held = 1;
      end else if (gvalid) begin
        held++;
      end
      if (gvalid && held == 2) nreq[gidx] = 1'b1;
      if (!gvalid) nreq = 8'h00;
      pv = gvalid;
      prev = ngrant;
    end
    n_tests++; if (ngr != 9) begin n_fail++; $display("FAIL rr_count: got %0d grants want 9", ngr); end
    nreq = 8'hFF;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    nreq = 8'hDF;
    wait_grant(6, ok);
    n_tests++; if (!ok || gidx !== 3'd5) begin
      n_fail++; $display("FAIL to_first: got ok=%b gidx=%0d want 1/5", ok, gidx); end
    nreq = 8'hDD;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      n_tests++; if (ngrant !== 8'hDF || ntimeout !== 1'b1) begin
        n_fail++; $display("FAIL to_hold%0d: got ngrant=%h ntimeout=%b want df/1", c, ngrant, ntimeout); end
    end
    @(negedge clk);
    n_tests++; if (ngrant !== 8'hFF || gvalid !== 1'b0 || ntimeout !== 1'b0 || gidx !== 3'd5) begin
      n_fail++; $display("FAIL to_release: got ngrant=%h gvalid=%b ntimeout=%b gidx=%0d want ff/0/0/5",
                         ngrant, gvalid, ntimeout, gidx); end
    @(negedge clk);
    n_tests++; if (ntimeout !== 1'b1 || ngrant !== 8'hFF) begin
      n_fail++; $display("FAIL to_pulse_end: got ntimeout=%b ngrant=%h want 1/ff", ntimeout, ngrant); end
    @(negedge clk);
    n_tests++; if (gidx !== 3'd1 || ngrant !== 8'hFD) begin
      n_fail++; $display("FAIL to_next: got gidx=%0d ngrant=%h want 1/fd", gidx, ngrant); end
    @(negedge clk);
    nreq = 8'hDF;
    wait_grant(6, ok);
    n_tests++; if (!ok || gidx !== 3'd5 || ngrant !== 8'hDF) begin
      n_fail++; $display("FAIL to_regrant: got ok=%b gidx=%0d ngrant=%h want 1/5/df", ok, gidx, ngrant); end
    nreq = 8'hFF;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_enable();
    ng = 1'b1; nreq = 8'h00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++; if (gvalid !== 1'b0 || ngrant !== 8'hFF) begin
        n_fail++; $display("FAIL en_gated: got gvalid=%b ngrant=%h want 0/ff", gvalid, ngrant); end
    end
    ng = 1'b0;
    @(negedge clk);
    n_tests++; if (gidx !== 3'd6 || ngrant !== 8'hBF || gvalid !== 1'b1) begin
      n_fail++; $display("FAIL en_grant: got gidx=%0d ngrant=%h gvalid=%b want 6/bf/1", gidx, ngrant, gvalid); end
    @(negedge clk);
    ng = 1'b1;
    @(negedge clk);
    n_tests++; if (ngrant !== 8'hFF || gvalid !== 1'b0 || ntimeout !== 1'b1) begin
      n_fail++; $display("FAIL en_forced: got ngrant=%h gvalid=%b ntimeout=%b want ff/0/1", ngrant, gvalid, ntimeout); end
    @(negedge clk);
    n_tests++; if (ntimeout !== 1'b1) begin n_fail++; $display("FAIL en_nopulse: got %b want 1", ntimeout); end
    nreq = 8'hFF; ng = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_x_robust();
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    nreq = 8'bxxxx_xx10;
    @(negedge clk);
    n_tests++; if (gidx !== 3'd0 || ngrant !== 8'hFE || gvalid !== 1'b1) begin
      n_fail++; $display("FAIL x_grant: got gidx=%0d ngrant=%h gvalid=%b want 0/fe/1", gidx, ngrant, gvalid); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++; if ($isunknown(ngrant) || ngrant !== 8'hFE) begin
        n_fail++; $display("FAIL x_hold: got ngrant=%h want fe", ngrant); end
    end
    nreq = 8'hFF;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_reset_mid_grant();
    test_round_robin();
    test_timeout();
    test_enable();
    test_x_robust();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_arbiter.md
Name: demux_arbiter

Overview:
- Round-robin arbiter sharing one decoded resource (a 3-to-8 decoder-selected bus or device strobe group) between 8 requesters.
- Outputs an active-low one-hot grant vector, in the same form as the decoder output, plus the binary grant index.
- Guarantees at least one all-high (nobody selected) cycle between consecutive grants, so decoder enable skew cannot produce overlapping selects.
- Bounds grant length with a hold timeout.

Parameters:
- DEAD_CYCLES, 1: extra all-high cycles inserted after each release (0..15). The gap between grants is DEAD_CYCLES+1 cycles.
- MAX_HOLD, 16: maximum cycles a grant may be held (1..255). 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- nreq  input  8  active-low requests; bit i low means requester i wants the resource.
- ng  input  1  active-low arbiter enable (G2-style).
- ngrant  output  8  active-low one-hot grant; 8'hFF when nobody is granted.
- gidx  output  3  binary index of the current or last granted requester.
- gvalid  output  1  high while a grant is active.
- ntimeout  output  1  active-low single-cycle pulse when a grant is force-released by timeout.

Behaviour:
- Reset (nreset low), asynchronous and immediate, including mid-grant:
  - ngrant=8'hFF, gidx=0, gvalid=0, ntimeout=1.
  - Internal: priority pointer ptr=0, hold timer=0, dead counter=0, state=IDLE.
- Registered outputs: all outputs come from flops; no combinational path from nreq to ngrant.
- Request decoding: a request bit counts as asserted only if it is exactly 0. X or Z counts as not asserted, matching the decoder's all-high default.
- State IDLE:
  - If ng=0 and any request is asserted, pick the first asserted index scanning upward from ptr with wrap 7->0.
  - On the next edge: ngrant[i]=0, gidx=i, gvalid=1, timer=1, state=GRANT.
  - Request-to-grant latency is exactly 1 clock.
  - If ng=1 or no request is asserted, stay in IDLE with outputs unchanged.
- State GRANT (holder i). Release happens on the next edge when any of these is true:
  - nreq[i]=1 (voluntary release);
  - ng=1 (forced release, no timeout pulse);
  - MAX_HOLD!=0 and timer==MAX_HOLD (timeout release; ntimeout=0 for exactly that one cycle).
- Release edge actions:
  - ngrant=8'hFF, gvalid=0; gidx keeps i.
  - ptr=(i+1) mod 8, so the releaser becomes lowest priority.
  - Next state is DEAD if DEAD_CYCLES>0, otherwise IDLE.
- Timer increments each GRANT cycle and saturates. Grant duration on timeout is exactly MAX_HOLD cycles.
- Changes on other requesters' nreq bits during GRANT have no effect.
- State DEAD:
  - Counts DEAD_CYCLES cycles with ngrant=8'hFF, then returns to IDLE.
  - Requests arriving during DEAD are only evaluated once back in IDLE.
- Timed-out requester still requesting: competes again from IDLE at lowest priority. It wins only if nobody else is requesting.
- Simultaneous events:
  - Voluntary release and timeout on the same cycle count as a timeout (pulse asserted).
  - ng=1 coinciding with timeout gives no pulse; ng takes precedence.
- Invariant: at most one bit of ngrant is low at any time, and never a low bit when gvalid=0.
- Sizing: timer width is 8 bits; dead counter width is 4 bits.

Decomposition:
- Shared package (demux_pkg):
  - state encoding IDLE=2'd0, GRANT=2'd1, DEAD=2'd2;
  - constants NREQ=8, IDXW=3, NONE_SEL=8'hFF.
- One sub-module: rr_priority_8.
  - Purely combinational rotating priority picker.
  - Inputs: 8-bit active-high request vector and 3-bit ptr.
  - Outputs: 3-bit index and found flag.
- The top level holds the FSM, timer, dead counter and output registers.

Test Plan:
- Reset mid-grant: hold nreq=8'hFB until grant to 2, then pulse nreset low -> ngrant=8'hFF, gvalid=0, gidx=0 immediately, asynchronously to clk.
- Single requester: nreq=8'hF7 from IDLE -> ngrant=8'hF7, gidx=3, gvalid=1 one edge later. Release nreq=8'hFF -> ngrant=8'hFF next edge, then a DEAD_CYCLES+1 cycle gap before any new grant.
- Round robin: all requesters hold nreq=8'h00, each releasing after 2 cycles -> grant order 0,1,2,...,7,0. ngrant is never two bits low and never back-to-back without an all-high cycle.
- Timeout: MAX_HOLD=4, requester 5 holds continuously and requester 1 is also requesting -> grant 5 lasts exactly 4 cycles, ntimeout low for one cycle, the next grant goes to 1, and 5 is granted after 1 releases.
- Enable gating: ng=1 while nreq=8'h00 -> no grant. Deassert ng (set ng=0) -> grant to ptr. Set ng=1 mid-grant -> release next edge with ntimeout staying 1.
- X robustness: nreq=8'bxxxx_xx10 -> only requester 0 counts as asserted and is granted; ngrant never goes X.
